// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: parametrised UART transmitter (width/parity/stop) with a
// one-deep holding register so the next byte can queue behind the current frame.
module uart_tx_fifo_cfg #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_ready,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);
    localparam int SMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [NW-1:0] n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] h_q, h_d;
    logic          p_q, p_d;
    logic          hv_q, hv_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;

    function automatic logic par_of(input logic [DBIT-1:0] v);
        return (^v) ^ PARITY_ODD;
    endfunction

    assign accept = tx_start & ready_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        h_d     = h_q;
        hv_d    = hv_q;
        done_d  = 1'b0;
        // Only a truly idle transmitter bypasses the holding register
        if (accept && state_q != IDLE) begin
            h_d  = din;
            hv_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (hv_q) begin
                    b_d     = h_q;
                    p_d     = par_of(h_q);
                    hv_d    = 1'b0;
                    s_d     = '0;
                    state_d = START;
                end else if (accept) begin
                    b_d     = din;
                    p_d     = par_of(din);
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = PARITY_EN ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        s_d    = '0;
                        done_d = 1'b1;
                        // Chain the queued byte straight into a start bit
                        if (hv_q) begin
                            b_d     = h_q;
                            p_d     = par_of(h_q);
                            hv_d    = 1'b0;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = p_d;
            default: tx_d = 1'b1;
        endcase
        ready_d = ~hv_d;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            h_q     <= '0;
            hv_q    <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            h_q     <= h_d;
            hv_q    <= hv_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_ready     = ready_q;
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;
endmodule
